// File: rtl/armleo_round_robin_pkg.sv
// -----------------------------------------------------------------------------
// armleo_round_robin_pkg
// Shared helpers for the round-robin arbiter slice.
//   - RR_MIN_WIDTH / RR_MAX_WIDTH : supported requester-count range.
//   - rr_next_index()             : modulo-width increment used to advance the
//                                   priority pointer past the granted requester.
// -----------------------------------------------------------------------------
package armleo_round_robin_pkg;

    localparam int RR_MIN_WIDTH = 32'sd2;
    localparam int RR_MAX_WIDTH = 32'sd64;

    // Next priority index after idx, wrapping width-1 back to 0, so the
    // pointer can never reach an out-of-range value for non-power-of-two widths.
    function automatic int rr_next_index(input int idx, input int width);
        int nxt;
        if (idx >= (width - 32'sd1)) begin
            nxt = 32'sd0;
        end else begin
            nxt = idx + 32'sd1;
        end
        return nxt;
    endfunction

endpackage : armleo_round_robin_pkg

// File: rtl/armleo_onehot_to_idx.sv
// -----------------------------------------------------------------------------
// armleo_onehot_to_idx
// WIDTH-parametric one-hot (or zero) to binary encoder.
// Ports:
//   onehot : input  [WIDTH-1:0]  one-hot or all-zero vector
//   idx    : output [IDX_W-1:0]  position of the set bit, 0 when onehot is 0
// Built as an OR of the indices of all set bits, which is exact for one-hot
// input and needs no priority chain.
// -----------------------------------------------------------------------------
module armleo_onehot_to_idx #(
    parameter  int WIDTH = 5,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx
);

    // OR together the index of every set bit.
    always_comb begin
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
    end

endmodule : armleo_onehot_to_idx

// File: rtl/armleo_round_robin.sv
// -----------------------------------------------------------------------------
// armleo_round_robin
// Round-robin arbiter with a single priority pointer.
// Ports:
//   clk       : input              rising-edge clock
//   rst_n     : input              synchronous active-low reset (ptr -> 0)
//   request   : input  [WIDTH-1:0] bit i set: requester i wants the grant
//   grant     : output [WIDTH-1:0] one-hot (or zero) grant, combinational
//   grant_idx : output [IDX_W-1:0] binary index of the grant bit (0 if none)
//   ack       : input              accepts the current grant, advances ptr
// Optional feature: define ARMLEO_ROUND_ROBIN_ASSERT_EN to compile in
// simulation assertions on the grant/pointer invariants.
// -----------------------------------------------------------------------------
module armleo_round_robin
    import armleo_round_robin_pkg::*;
#(
    parameter  int WIDTH = 5,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] request,
    output logic [WIDTH-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    input  logic             ack
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    logic [WIDTH-1:0] high_mask_s;
    logic [WIDTH-1:0] masked_req_s;
    logic [WIDTH-1:0] masked_pick_s;
    logic [WIDTH-1:0] plain_pick_s;

    // Two priority passes: lowest set bit at or above ptr, else lowest set bit
    // overall. x & (-x) isolates the lowest set bit without a search loop.
    always_comb begin
        high_mask_s   = {WIDTH{1'b1}} << ptr_q;
        masked_req_s  = request & high_mask_s;
        masked_pick_s = masked_req_s & (~masked_req_s + {{(WIDTH-1){1'b0}}, 1'b1});
        plain_pick_s  = request & (~request + {{(WIDTH-1){1'b0}}, 1'b1});
        if (masked_req_s != {WIDTH{1'b0}}) begin
            grant = masked_pick_s;
        end else begin
            grant = plain_pick_s;
        end
    end

    armleo_onehot_to_idx #(
        .WIDTH (WIDTH)
    ) u_onehot_to_idx (
        .onehot (grant),
        .idx    (grant_idx)
    );

    // Next pointer: move just past an accepted grant, otherwise hold.
    always_comb begin
        if (ack && (grant != {WIDTH{1'b0}})) begin
            ptr_d = IDX_W'(rr_next_index(32'(grant_idx), WIDTH));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register; reset makes requester 0 highest priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= {IDX_W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

`ifdef ARMLEO_ROUND_ROBIN_ASSERT_EN
    // Invariant checks on every clock out of reset.
    always @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0(grant))
                else $error("armleo_round_robin: grant not one-hot/zero %b", grant);
            assert ((grant & ~request) == {WIDTH{1'b0}})
                else $error("armleo_round_robin: grant %b not subset of request %b", grant, request);
            assert ((grant == {WIDTH{1'b0}}) ? (grant_idx == {IDX_W{1'b0}}) : grant[grant_idx])
                else $error("armleo_round_robin: grant_idx %0d inconsistent with grant %b", grant_idx, grant);
            assert (32'(ptr_q) < WIDTH)
                else $error("armleo_round_robin: ptr %0d out of range", ptr_q);
        end else begin
        end
    end
`else
    // No invariant checks in this build.
`endif

endmodule : armleo_round_robin

// File: tb/tb_armleo_round_robin.sv
// -----------------------------------------------------------------------------
// tb_armleo_round_robin
// Directed and random stimulus for armleo_round_robin (WIDTH=5) compared with
// a behavioural model: a priority pointer and a modulo-WIDTH linear search.
// -----------------------------------------------------------------------------
module tb_armleo_round_robin;

    localparam int W = 5;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] request;
    logic [W-1:0] grant;
    logic [2:0]   grant_idx;
    logic         ack;

    int checks;
    int failures;
    int model_ptr;

    armleo_round_robin #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .request   (request),
        .grant     (grant),
        .grant_idx (grant_idx),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: first requester found walking p, p+1, ... modulo W.
    function automatic int model_idx(input logic [W-1:0] req, input int p);
        for (int k = 0; k < W; k++) begin
            int j;
            j = (p + k) % W;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check the combinational outputs mid-cycle,
    // then clock and advance the model. exp_idx >= 0 adds a fixed-value check.
    task automatic step(input string tag, input logic [W-1:0] req, input logic a,
                        input logic r, input int exp_idx);
        int mi;
        logic [W-1:0] eg;
        request = req;
        ack     = a;
        rst_n   = r;
        #2;
        mi = model_idx(req, model_ptr);
        eg = (mi < 0) ? 5'b00000 : (5'b00001 << mi);
        chk({tag, ".grant"}, 32'(grant), 32'(eg));
        chk({tag, ".idx"}, 32'(grant_idx), (mi < 0) ? 32'd0 : 32'(mi));
        chk({tag, ".ptr"}, 32'(dut.ptr_q), 32'(model_ptr));
        if (exp_idx >= 0) begin
            chk({tag, ".fixed"}, 32'(grant_idx), 32'(exp_idx));
        end else begin
        end
        @(posedge clk);
        if (!r) model_ptr = 0;
        else if (a && (mi >= 0)) model_ptr = (mi + 1) % W;
        else model_ptr = model_ptr;
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        request   = 5'b00000;
        ack       = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        model_ptr = 0;

        // Idle request pattern without ack: grant stays on requester 1.
        step("hold0", 5'b10110, 1'b0, 1'b1, 1);
        step("hold1", 5'b10110, 1'b0, 1'b1, 1);
        step("hold2", 5'b10110, 1'b0, 1'b1, 1);

        // Rotation over a sparse request, wrapping past 4.
        step("rot0", 5'b10110, 1'b1, 1'b1, 1);
        step("rot1", 5'b10110, 1'b1, 1'b1, 2);
        step("rot2", 5'b10110, 1'b1, 1'b1, 4);
        step("rot3", 5'b10110, 1'b1, 1'b1, 1);
        step("rot4", 5'b10110, 1'b1, 1'b1, 2);

        // Full request rotation from reset.
        step("rst_a", 5'b11111, 1'b1, 1'b0, -1);
        for (int i = 0; i < 6; i++) begin
            step("full", 5'b11111, 1'b1, 1'b1, i % W);
        end

        // No request with ack: ptr (now 1) must hold.
        step("empty", 5'b00000, 1'b1, 1'b1, 0);
        step("after_empty", 5'b11111, 1'b0, 1'b1, 1);
        step("rst_b", 5'b00000, 1'b0, 1'b0, -1);
        step("ptr0_full", 5'b11111, 1'b0, 1'b1, 0);

        // Reset mid-rotation discards history.
        step("mid0", 5'b11111, 1'b1, 1'b1, 0);
        step("mid1", 5'b11111, 1'b1, 1'b1, 1);
        step("mid2", 5'b11111, 1'b1, 1'b1, 2);
        step("mid_rst", 5'b11111, 1'b1, 1'b0, 3);
        step("post_rst", 5'b11111, 1'b0, 1'b1, 0);

        // Grant tracks request changes without ack.
        step("track0", 5'b01000, 1'b0, 1'b1, 3);
        step("track1", 5'b00010, 1'b0, 1'b1, 1);

        // Random traffic with occasional reset.
        for (int i = 0; i < 300; i++) begin
            step("rand", 5'($urandom_range(0, 31)), 1'($urandom % 2),
                 1'(($urandom % 20) != 0), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_armleo_round_robin

// File: doc/armleo_round_robin.md
ARMLEO_ROUND_ROBIN -- requirements
Module: armleo_round_robin

Interface
REQ-001 SHALL have parameter WIDTH, default 5, giving the number of requesters; legal range 2..64.
REQ-002 SHALL define localparam IDX_W = $clog2(WIDTH), the width of grant_idx.
REQ-003 SHALL use reset rst_n, synchronous, active-low; clock clk.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 request  input  WIDTH  bit i high means requester i asks for the grant.
REQ-007 grant  output  WIDTH  one-hot (or zero) granted requester.
REQ-008 grant_idx  output  IDX_W  binary index of the set grant bit.
REQ-009 ack  input  1  accepts the current grant and advances priority.

Function
REQ-010 SHALL hold one state register, ptr (IDX_W bits), the index of the highest-priority requester.
REQ-011 grant SHALL be combinational from request and ptr, with zero-cycle latency from request to grant.
REQ-012 grant SHALL select the first set request bit searching ptr, ptr+1, ..., WIDTH-1, 0, ..., ptr-1, wrapping modulo WIDTH.
REQ-013 grant SHALL be all-zero when request is zero, and SHALL never have more than one bit set.
REQ-014 grant SHALL always be a subset of request (grant & ~request == 0).
REQ-015 grant_idx SHALL equal the position of the set grant bit, and SHALL be 0 when grant is zero.
REQ-016 On a clock edge with ack=1 and grant nonzero, ptr SHALL become grant_idx+1, with WIDTH-1 wrapping to 0.
REQ-017 On a clock edge with ack=0, or with ack=1 and request zero, ptr SHALL hold its value.
REQ-018 Without ack, grant SHALL track request changes combinationally and SHALL NOT be latched.
REQ-019 ack SHALL be sampled in the same cycle as the grant it acknowledges; there is no handshake beyond this.
REQ-020 Out-of-range ptr values SHALL be unreachable: ptr SHALL stay in 0..WIDTH-1 for non-power-of-two WIDTH.

Reset
REQ-021 When rst_n=0 at a rising edge, ptr SHALL become 0, regardless of ack; requester 0 is then highest priority.
REQ-022 During reset, grant and grant_idx SHALL remain the combinational functions of request and the current ptr.
REQ-023 After reset with request all-ones, grant SHALL be 1 and grant_idx SHALL be 0.
REQ-024 Assertion of reset in the middle of a rotation SHALL discard all rotation history.

Configuration
REQ-025 With macro ARMLEO_ROUND_ROBIN_ASSERT_EN defined, the following SHALL be compiled in as simulation assertions, checked each clock when rst_n=1:
- grant is one-hot or zero;
- grant is a subset of request;
- grant_idx is consistent with grant;
- ptr is less than WIDTH.
REQ-026 Without ARMLEO_ROUND_ROBIN_ASSERT_EN, no assertion code SHALL exist, and the synthesized logic SHALL be identical.

Structure
REQ-027 No shared package content is required; IDX_W SHALL remain a local parameter.
REQ-028 One sub-module is natural: armleo_onehot_to_idx, a WIDTH-parametric one-hot to binary encoder producing grant_idx.
REQ-029 The rotating search SHALL be built from two masked priority passes, without a WIDTH-deep loop-carried state chain:
- a masked pass over indices at or above ptr;
- an unmasked fallback pass.

Verification (WIDTH=5)
REQ-030 Reset, request=10110, ack=0 -> grant=00010, grant_idx=1; grant unchanged over 3 cycles.
REQ-031 request=10110, ack=1 every cycle -> grant_idx sequence 1, 2, 4, 1, 2 (wrap past 4 to 1).
REQ-032 request=11111, ack=1 every cycle -> grant_idx sequence 0, 1, 2, 3, 4, 0.
REQ-033 request=00000, ack=1 -> grant=00000, grant_idx=0, and ptr is unchanged.
- Following step: request=11111 with ptr at 0 -> grant_idx=0.
REQ-034 Rotate until ptr=3, then hold rst_n=0 for one edge, then request=11111 -> grant=00001.
REQ-035 request changes 01000 -> 00010 with ack=0 -> grant follows in the same cycle (01000 then 00010); ptr is unchanged.
